// File: rtl/call_register.sv
// Elevator call register: synchronizes and debounces the floor and door
// buttons, then latches floor calls until the car services that floor with
// the door open. Button index map: 0..7 floors G..F7, 8 door-open, 9 door-close.
module call_register #(
    // Consecutive stable synchronized samples needed to accept a change (2..15)
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn,
    input  logic       btn_open,
    input  logic       btn_close,
    input  logic       door_open,
    input  logic [2:0] floor,
    output logic [7:0] req,
    output logic       inopen,
    output logic       inclose,
    output logic       req_any,
    output logic [3:0] req_count
);

    localparam int         NB      = 10;
    localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

    logic [NB-1:0]      rawBtn;
    logic [NB-1:0]      sync1_q;
    logic [NB-1:0]      sync2_q;
    logic [NB-1:0]      stable_q;
    logic [NB-1:0]      stable_d;
    logic [NB-1:0][3:0] cnt_q;
    logic [NB-1:0][3:0] cnt_d;
    logic [7:0]         prevStable_q;
    logic [7:0]         req_q;
    logic [7:0]         req_d;
    logic [7:0]         pressEvent;
    logic [7:0]         clearMask;

    assign rawBtn = {btn_close, btn_open, btn};

    // Two-flop synchronizer per button; nothing else touches the raw inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rawBtn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a disagreeing sample advances the counter, an agreeing one
    // restarts it, and the level flips only after DB_CYCLES disagreeing samples in a row
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
    end

    // Debounce counters and accepted stable levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Previous stable floor levels, used to find the one-cycle rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevStable_q <= '0;
        end else begin
            prevStable_q <= stable_q[7:0];
        end
    end

    assign pressEvent = stable_q[7:0] & ~prevStable_q;

    // Servicing the current floor with the door open clears that call, and the
    // clear beats a press arriving in the same cycle
    always_comb begin
        clearMask = '0;
        if (door_open) begin
            clearMask[floor] = 1'b1;
        end
        req_d = (req_q | pressEvent) & ~clearMask;
    end

    // Latched pending calls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    // Population count of pending calls, straight off the register
    always_comb begin
        req_count = '0;
        for (int i = 0; i < 8; i++) begin
            req_count = req_count + {3'b000, req_q[i]};
        end
    end

    assign req     = req_q;
    assign req_any = |req_q;
    assign inopen  = stable_q[8];
    assign inclose = stable_q[9] & ~stable_q[8];

endmodule

// File: tb/tb_call_register.sv
// Testbench for call_register: a stimulus table stepped in a loop plus
// hand-written sequences for bounce rejection, press/clear collision and
// asynchronous reset; expectations go through a scoreboard queue.
module tb_call_register;

    logic       clk;
    logic       rst;
    logic [7:0] btn;
    logic       btn_open;
    logic       btn_close;
    logic       door_open;
    logic [2:0] floor;
    logic [7:0] req;
    logic       inopen;
    logic       inclose;
    logic       req_any;
    logic [3:0] req_count;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic [7:0] btn;
        logic       bOpen;
        logic       bClose;
        logic       door;
        logic [2:0] flr;
        int         edges;
        logic [7:0] expReq;
        logic       expOpen;
        logic       expClose;
    } vec_t;

    typedef struct {
        logic [7:0] req;
        logic       open;
        logic       close;
    } expect_t;

    vec_t    vecs [22];
    expect_t sbQ [$];

    call_register #(.DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .btn_open  (btn_open),
        .btn_close (btn_close),
        .door_open (door_open),
        .floor     (floor),
        .req       (req),
        .inopen    (inopen),
        .inclose   (inclose),
        .req_any   (req_any),
        .req_count (req_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, need completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] b, input logic o, input logic c,
                                 input logic d, input logic [2:0] f);
        btn       = b;
        btn_open  = o;
        btn_close = c;
        door_open = d;
        floor     = f;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pushExpect(input logic [7:0] r, input logic o, input logic c);
        expect_t e;
        e.req   = r;
        e.open  = o;
        e.close = c;
        sbQ.push_back(e);
    endtask

    task automatic compareField(input string name, input string field,
                                input logic [7:0] act, input logic [7:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        expect_t    e;
        logic [7:0] expCount;
        if (sbQ.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL %s: scoreboard empty, got no expectation, need one", name);
        end else begin
            e        = sbQ.pop_front();
            expCount = 8'($countones(e.req));
            compareField(name, "req",       req,                  e.req);
            compareField(name, "inopen",    {7'b0, inopen},       {7'b0, e.open});
            compareField(name, "inclose",   {7'b0, inclose},      {7'b0, e.close});
            compareField(name, "req_count", {4'b0, req_count},    expCount);
            compareField(name, "req_any",   {7'b0, req_any},      {7'b0, |e.req});
        end
    endtask

    task automatic runStep(input logic [7:0] b, input logic o, input logic c,
                           input logic d, input logic [2:0] f, input int edges,
                           input logic [7:0] er, input logic eo, input logic ec,
                           input string name);
        applyStimulus(b, o, c, d, f);
        pushExpect(er, eo, ec);
        waitEdges(edges);
        checkOutput(name);
    endtask

    initial begin
        logic [5:0] bounce;

        // Table: btn, open, close, door, floor, edges, expReq, expOpen, expClose
        vecs[0]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 6, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1, 8'h08, 1'b0, 1'b0};
        vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8, 8'h08, 1'b0, 1'b0};
        vecs[3]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{8'h24, 1'b0, 1'b0, 1'b0, 3'd0, 6, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{8'h24, 1'b0, 1'b0, 1'b0, 3'd0, 1, 8'h24, 1'b0, 1'b0};
        vecs[6]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 1, 8'h20, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 1, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{8'h02, 1'b0, 1'b0, 1'b0, 3'd0, 7, 8'h02, 1'b0, 1'b0};
        vecs[10] = '{8'h02, 1'b0, 1'b0, 1'b1, 3'd1, 1, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{8'h02, 1'b0, 1'b0, 1'b0, 3'd0, 6, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{8'h80, 1'b0, 1'b0, 1'b0, 3'd0, 7, 8'h80, 1'b0, 1'b0};
        vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 1, 8'h80, 1'b0, 1'b0};
        vecs[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8, 8'h80, 1'b0, 1'b0};
        vecs[16] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 1, 8'h00, 1'b0, 1'b0};
        vecs[17] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 5, 8'h00, 1'b0, 1'b0};
        vecs[18] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1, 8'h00, 1'b1, 1'b0};
        vecs[19] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 5, 8'h00, 1'b1, 1'b0};
        vecs[20] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1, 8'h00, 1'b0, 1'b1};
        vecs[21] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8, 8'h00, 1'b0, 1'b0};

        // Reset state
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        pushExpect(8'h00, 1'b0, 1'b0);
        waitEdges(3);
        checkOutput("reset");
        rst = 1'b0;

        // Table-driven steps: latency, clears, held button, other floors, door buttons
        for (int i = 0; i < 22; i++) begin
            runStep(vecs[i].btn, vecs[i].bOpen, vecs[i].bClose, vecs[i].door,
                    vecs[i].flr, vecs[i].edges, vecs[i].expReq, vecs[i].expOpen,
                    vecs[i].expClose, $sformatf("vec%0d", i));
        end

        // Bouncy short press on floor 5 must be rejected
        bounce = 6'b101110;
        for (int i = 5; i >= 0; i--) begin
            applyStimulus({2'b00, bounce[i], 5'b00000}, 1'b0, 1'b0, 1'b0, 3'd0);
            waitEdges(1);
        end
        runStep(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4, 8'h00, 1'b0, 1'b0, "bounce_reject");
        runStep(8'h20, 1'b0, 1'b0, 1'b0, 3'd0, 10, 8'h20, 1'b0, 1'b0, "hold5");
        runStep(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 10, 8'h20, 1'b0, 1'b0, "release5");
        runStep(8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 1, 8'h00, 1'b0, 1'b0, "clear5");

        // Press event on floor 3 colliding with a clear of floor 3, then with floor 4
        applyStimulus(8'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        waitEdges(6);
        runStep(8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 1, 8'h00, 1'b0, 1'b0, "press_vs_clear");
        runStep(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8, 8'h00, 1'b0, 1'b0, "release3");
        applyStimulus(8'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        waitEdges(6);
        runStep(8'h08, 1'b0, 1'b0, 1'b1, 3'd4, 1, 8'h08, 1'b0, 1'b0, "press_other_floor");
        runStep(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8, 8'h08, 1'b0, 1'b0, "release3b");

        // All floors, then asynchronous reset while held, then re-registration
        runStep(8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 7, 8'hFF, 1'b0, 1'b0, "all_floors");
        rst = 1'b1;
        pushExpect(8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("async_reset");
        waitEdges(2);
        rst = 1'b0;
        runStep(8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 6, 8'h00, 1'b0, 1'b0, "rereg_edge6");
        runStep(8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1, 8'hFF, 1'b0, 1'b0, "rereg_edge7");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/call_register.md
CALL_REGISTER -- requirements
Module: call_register

Interface
REQ-001 Parameter: DB_CYCLES, 4, number of consecutive stable synchronized samples needed to accept a button level change (legal range 2..15).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 btn  input  8  raw floor call buttons, bit f = floor f (0 = G .. 7 = F7), asynchronous and bouncing, active-high.
REQ-005 btn_open  input  1  raw door-open button, asynchronous, active-high.
REQ-006 btn_close  input  1  raw door-close button, asynchronous, active-high.
REQ-007 door_open  input  1  controller door-open status (high while controller is in its OPEN state).
REQ-008 floor  input  3  controller current floor, 0..7.
REQ-009 req  output  8  latched pending calls, bit f drives the controller's floor-f call input (inG..in7).
REQ-010 inopen  output  1  debounced door-open level to controller.
REQ-011 inclose  output  1  debounced door-close level to controller.
REQ-012 req_any  output  1  high when any req bit is set.
REQ-013 req_count  output  4  number of set req bits, 0..8.

Function
REQ-014 Each of the 10 raw buttons SHALL pass through its own 2-flop synchronizer; no other logic samples raw inputs.
REQ-015 Each button SHALL own a debounce counter and a registered stable level; on each edge: if sync output equals stable, counter <= 0; else if counter == DB_CYCLES-1, stable <= sync output and counter <= 0; else counter++.
REQ-016 A level change lasting fewer than DB_CYCLES consecutive synchronized samples SHALL never alter stable.
REQ-017 A floor press event SHALL be the rising edge of a floor button's stable level (stable high, registered previous stable low), one cycle wide.
REQ-018 Latency: a raw floor button rising before edge 1 and held SHALL set req[f] after edge DB_CYCLES+3 (edge 7 for default).
REQ-019 req[f] SHALL clear on the edge where door_open=1 and floor==f; clear SHALL take priority over a simultaneous press event for floor f.
REQ-020 A press event for floor f SHALL set req[f] on the next edge unless the clear condition for f holds that cycle; a press for an already-set bit SHALL leave it set.
REQ-021 Holding a floor button SHALL produce only one press event; re-registration requires release (stable low) then a new accepted press.
REQ-022 Bits other than the current floor SHALL be unaffected by door_open.
REQ-023 inopen SHALL equal the stable level of btn_open.
REQ-024 inclose SHALL equal the stable level of btn_close AND NOT stable btn_open (open wins when both held).
REQ-025 req_any and req_count SHALL be combinational from the req register only (no extra latency); req_count = popcount(req), zero-extended to 4 bits.
REQ-026 floor values are always 0..7; no out-of-range handling is required.

Reset
REQ-027 While rst is high, all synchronizer flops, stable levels, previous-stable flops, debounce counters and req SHALL be 0; therefore req=0, inopen=0, inclose=0, req_any=0, req_count=0.
REQ-028 Reset asserted mid-debounce or with pending calls SHALL discard all partial counts and calls; a button still held at reset release SHALL be re-debounced and register as a new press (req set at edge DB_CYCLES+3 after release).

Verification
REQ-029 DB_CYCLES=4, btn=8'h08 held from reset release: req=8'h08 after edge 7, not after edge 6; req_count=1, req_any=1.
REQ-030 btn[5] pulses high for 3 cycles with bounce (1,0,1,1,1,0): req stays 8'h00; then held 10 cycles: req[5]=1, exactly one set, stays set after release.
REQ-031 req=8'h24 pending, floor=2, door_open=1 for one cycle: req=8'h20 next edge; floor=5, door_open=1: req=8'h00, req_any=0.
REQ-032 Press event for floor 3 coinciding with door_open=1, floor=3: req[3] remains 0; same press with floor=4: req[3]=1.
REQ-033 btn_open and btn_close both held: inopen=1, inclose=0; release btn_open: inclose=1 DB_CYCLES+2 edges later.
REQ-034 All 8 buttons pressed: req=8'hFF, req_count=8; assert rst mid-hold: all outputs 0 immediately (asynchronous), calls re-register after release.
